// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder
//   Watches a multiplexed, active-low 7-segment display bus and rebuilds the
//   digit shown at each position. A bus pattern is captured only after it has
//   been stable for STABLE_CYCLES consecutive samples. This filters out ghosting
//   and glitches while the digit selects change.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   sseg_digit_n          digit selects (active-low)
//   sseg_segment_n        segments a..g on bits 0..6 (active-low)
//   sseg_decimal_point_n  decimal point (active-low)
//   digit_value           decoded hex nibble per position, digit i = [4i+3:4i]
//   digit_dp              captured decimal point per position
//   digit_valid           last capture was a legal hex glyph or blank
//   digit_blank           last capture had no segments lit
//   update_pulse          one-cycle strobe on every capture
//   update_idx            position of the most recent capture (held)
//   scan_error            current sample has two or more selects active
module sseg_scan_decoder #(
    parameter  int NUM_DIGITS    = 8,
    parameter  int STABLE_CYCLES = 4,
    localparam int IW            = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CW            = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   sseg_digit_n,
    input  logic [6:0]              sseg_segment_n,
    input  logic                    sseg_decimal_point_n,
    output logic [4*NUM_DIGITS-1:0] digit_value,
    output logic [NUM_DIGITS-1:0]   digit_dp,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic                    update_pulse,
    output logic [IW-1:0]           update_idx,
    output logic                    scan_error
);

    localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, TRACK, CAPTURE, HELD} state_t;

    state_t                  state, state_nx;
    logic [NUM_DIGITS-1:0]   sel, sel_prev;
    logic [6:0]              seg, seg_prev;
    logic                    dp, dp_prev;
    logic [CW-1:0]           cnt;
    logic                    one_hot, changed, stable, capture;
    logic [IW-1:0]           sel_idx;
    logic [5:0]              dec;  // {valid, blank, value[3:0]}

    // Sample stage. cnt is the number of consecutive samples equal to the one
    // now held in S. It is loaded together with S, so "cnt == STABLE_CYCLES"
    // is visible in the cycle when the pattern becomes stable enough. A value
    // of 1 marks a sample that differs from S_prev.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel      <= '0;
            seg      <= '0;
            dp       <= 1'b0;
            sel_prev <= '0;
            seg_prev <= '0;
            dp_prev  <= 1'b0;
            cnt      <= '0;
        end else begin
            sel      <= ~sseg_digit_n;
            seg      <= ~sseg_segment_n;
            dp       <= ~sseg_decimal_point_n;
            sel_prev <= sel;
            seg_prev <= seg;
            dp_prev  <= dp;
            if ({~sseg_digit_n, ~sseg_segment_n, ~sseg_decimal_point_n} != {sel, seg, dp})
                cnt <= CW'(1);
            else if (cnt != STABLE_C)
                cnt <= cnt + 1'b1;
        end
    end

    assign one_hot    = $onehot(sel);
    assign changed    = {sel, seg, dp} != {sel_prev, seg_prev, dp_prev};
    assign stable     = (cnt == STABLE_C);
    assign scan_error = ($countones(sel) > 1);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (sel[i]) sel_idx = IW'(i);
    end

    always_comb begin
        dec = 6'b00_0000;
        unique case (seg)
            7'h00: dec = 6'b11_0000;
            7'h3F: dec = 6'b10_0000;
            7'h06: dec = 6'b10_0001;
            7'h5B: dec = 6'b10_0010;
            7'h4F: dec = 6'b10_0011;
            7'h66: dec = 6'b10_0100;
            7'h6D: dec = 6'b10_0101;
            7'h7D: dec = 6'b10_0110;
            7'h07: dec = 6'b10_0111;
            7'h7F: dec = 6'b10_1000;
            7'h6F: dec = 6'b10_1001;
            7'h77: dec = 6'b10_1010;
            7'h7C: dec = 6'b10_1011;
            7'h39: dec = 6'b10_1100;
            7'h5E: dec = 6'b10_1101;
            7'h79: dec = 6'b10_1110;
            7'h71: dec = 6'b10_1111;
            default: dec = 6'b00_0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // CAPTURE is handled like HELD. If the pins move on the same edge that
    // starts a capture, the change is still seen and the new pattern is
    // tracked. With STABLE_CYCLES = 1 a changed one-hot sample is already
    // stable, so it is captured on the next edge.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        unique case (state)
            IDLE, TRACK: begin
                if (!one_hot)    state_nx = IDLE;
                else if (stable) begin state_nx = CAPTURE; capture = 1'b1; end
                else             state_nx = TRACK;
            end
            CAPTURE, HELD: begin
                if (!changed)     state_nx = HELD;
                else if (!one_hot) state_nx = IDLE;
                else if (stable)  begin state_nx = CAPTURE; capture = 1'b1; end
                else              state_nx = TRACK;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_value  <= '0;
            digit_dp     <= '0;
            digit_valid  <= '0;
            digit_blank  <= '0;
            update_pulse <= 1'b0;
            update_idx   <= '0;
        end else begin
            update_pulse <= capture;
            if (capture) begin
                digit_value[4*sel_idx +: 4] <= dec[3:0];
                digit_dp[sel_idx]           <= dp;
                digit_valid[sel_idx]        <= dec[5];
                digit_blank[sel_idx]        <= dec[4];
                update_idx                  <= sel_idx;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
module tb_sseg_scan_decoder;

    localparam int ND = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [ND-1:0] digit_n;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [4*ND-1:0] digit_value;
    logic [ND-1:0] digit_dp, digit_valid, digit_blank;
    logic          update_pulse;
    logic [2:0]    update_idx;
    logic          scan_error;

    sseg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .sseg_digit_n         (digit_n),
        .sseg_segment_n       (seg_n),
        .sseg_decimal_point_n (dp_n),
        .digit_value          (digit_value),
        .digit_dp             (digit_dp),
        .digit_valid          (digit_valid),
        .digit_blank          (digit_blank),
        .update_pulse         (update_pulse),
        .update_idx           (update_idx),
        .scan_error           (scan_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int         idx;
        logic [3:0] val;
        logic       dp;
        logic       valid;
        logic       blank;
        int         cyc;
    } exp_t;

    exp_t sbq[$];

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic exp_t model(input int idx, input logic [6:0] pat, input logic dpv);
        exp_t e;
        e.idx = idx; e.val = 4'h0; e.dp = dpv; e.valid = 1'b0; e.blank = 1'b0; e.cyc = 0;
        if (pat == 7'h00) begin
            e.valid = 1'b1;
            e.blank = 1'b1;
        end else begin
            for (int k = 0; k < 16; k++)
                if (glyph[k] == pat) begin
                    e.val   = 4'(k);
                    e.valid = 1'b1;
                end
        end
        return e;
    endfunction

    // Pins set at a falling edge are loaded at the next rising edge (edge n).
    // The capture lands at edge n+4, which is 5 counts after the drive.
    task automatic show(input int dig, input logic [6:0] pat, input logic dpv,
                        input int hold, input bit expect_cap);
        exp_t e;
        @(negedge clk);
        digit_n = ~(8'd1 << dig);
        seg_n   = ~pat;
        dp_n    = ~dpv;
        if (expect_cap) begin
            e = model(dig, pat, dpv);
            e.cyc = cyc + 5;
            sbq.push_back(e);
        end
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        digit_n = '1;
        seg_n   = '1;
        dp_n    = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_value"}, digit_value, 32'h0);
        chk({tag, "_dp"},    digit_dp,    32'h0);
        chk({tag, "_valid"}, digit_valid, 32'h0);
        chk({tag, "_blank"}, digit_blank, 32'h0);
        chk({tag, "_pulse"}, update_pulse, 32'h0);
        chk({tag, "_idx"},   update_idx,  32'h0);
        chk({tag, "_serr"},  scan_error,  32'h0);
    endtask

    // Scoreboard consumer: every capture strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && update_pulse) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("pulse_cyc", cyc, e.cyc);
                chk("upd_idx",   update_idx, e.idx);
                chk("value",     digit_value[e.idx*4 +: 4], e.val);
                chk("dp",        digit_dp[e.idx], e.dp);
                chk("valid",     digit_valid[e.idx], e.valid);
                chk("blank",     digit_blank[e.idx], e.blank);
            end
        end
    end

    initial begin
        reset   = 1'b1;
        digit_n = '1;
        seg_n   = '1;
        dp_n    = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        idle(3);

        // 1: single digit 0 at position 0, held 10 cycles
        show(0, 7'h3F, 1'b0, 10, 1'b1);
        idle(3);

        // 2: scan 0..7 across all positions
        for (int d = 0; d < ND; d++) show(d, glyph[d], 1'b0, 6, 1'b1);
        idle(3);
        chk("scan_value", digit_value, 32'h7654_3210);
        chk("scan_valid", digit_valid, 32'hFF);
        chk("scan_blank", digit_blank, 32'h00);

        // 3: short-lived "1" is filtered, the "2" that follows is captured
        show(2, 7'h06, 1'b0, 3, 1'b0);
        show(2, 7'h5B, 1'b0, 5, 1'b1);
        idle(3);

        // 4: two selects active -> scan_error, never captured
        @(negedge clk);
        digit_n = 8'hFC;
        seg_n   = ~7'h06;
        dp_n    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("scan_error", scan_error, 32'd1);
        end
        idle(3);
        chk("serr_clear", scan_error, 32'd0);

        // 5: illegal glyph, then blank with the decimal point lit
        show(3, 7'h01, 1'b0, 6, 1'b1);
        show(4, 7'h00, 1'b1, 6, 1'b1);
        idle(3);
        chk("illegal_valid", digit_valid[3], 32'd0);
        chk("blank_flags",   {digit_valid[4], digit_blank[4], digit_dp[4]}, 32'h7);

        // 6: asynchronous reset while HELD
        show(6, 7'h7D, 1'b0, 8, 1'b1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        reset   = 1'b0;
        digit_n = '1;
        seg_n   = '1;
        dp_n    = 1'b1;
        idle(2);
        show(1, 7'h4F, 1'b0, 6, 1'b1);
        idle(3);
        chk("post_rst_value", digit_value, 32'h30);
        chk("post_rst_valid", digit_valid, 32'h02);

        chk("sb_empty", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
